// File: rtl/dmem_wb_bridge_pkg.sv
// Shared constants and FSM encodings for the data-memory to Wishbone bridge.
// No logic; imported by dmem_wb_bridge.
package dmem_wb_bridge_pkg;

    localparam int                RegBus   = 32;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        WB_IDLE       = 2'd0,
        WB_BUSY       = 2'd1,
        WB_WAIT_STALL = 2'd2
    } wb_state_e;

endpackage

// File: rtl/dmem_wb_bridge.sv
// Purpose: turns each MEM-stage data access into one Wishbone B4 classic single-word cycle.
// Latency: cyc/stb after the request edge; load data and stall release in the ack cycle.
// Backpressure: stallreq_o holds the pipeline until ack; read data held while others stall.
module dmem_wb_bridge
    import dmem_wb_bridge_pkg::*;
#(
    parameter int DW = RegBus,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall_i,
    input  logic          flush_i,
    input  logic          cpu_ce_i,
    input  logic          cpu_we_i,
    input  logic [3:0]    cpu_sel_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_data_i,
    output logic [DW-1:0] cpu_data_o,
    output logic          stallreq_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_we_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_stb_o,
    output logic          wb_cyc_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i
);

    wb_state_e     state;
    logic [DW-1:0] rd_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WB_IDLE;
            rd_buf   <= '0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wb_adr_o <= cpu_addr_i;
                        wb_dat_o <= cpu_data_i;
                        wb_we_o  <= cpu_we_i;
                        wb_sel_o <= cpu_sel_i;
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        state    <= WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    // A flush kills the access even when the ack lands in the same cycle.
                    if (flush_i || wb_ack_i) begin
                        wb_adr_o <= '0;
                        wb_dat_o <= '0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                    end
                    if (flush_i) begin
                        state <= WB_IDLE;
                    end else if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            rd_buf <= wb_dat_i;
                        end
                        state <= (stall_i != '0) ? WB_WAIT_STALL : WB_IDLE;
                    end
                end
                WB_WAIT_STALL: begin
                    if (stall_i == '0 || flush_i) begin
                        state <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        if (rst) begin
            case (state)
                WB_IDLE: begin
                    stallreq_o = cpu_ce_i && !flush_i;
                end
                WB_BUSY: begin
                    if (!flush_i) begin
                        if (wb_ack_i) begin
                            cpu_data_o = wb_we_o ? '0 : wb_dat_i;
                        end else begin
                            stallreq_o = 1'b1;
                        end
                    end
                end
                WB_WAIT_STALL: begin
                    cpu_data_o = rd_buf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// Scoreboard bench for dmem_wb_bridge: load/store, ack delays, pipeline stall hold,
// flush abort with late ack, and asynchronous reset mid-transaction.
module tb_dmem_wb_bridge;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    dmem_wb_bridge #(.DW(32), .AW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] rdat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ack-cycle monitor: pops the expectation pushed by the stimulus.
    always @(negedge clk) begin
        if (rst && wb_cyc_o && wb_ack_i && !flush_i) begin
            if (sb.size() == 0) begin
                chk("sb_pending", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_data", cpu_data_o, e.we ? 32'h0 : e.rdat);
                chk("ack_stallreq", stallreq_o, 1'b0);
            end
        end
    end

    // Entered and left at #1 after a rising edge.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] wdat, input logic [31:0] rdat,
                             input int ack_delay, input logic [5:0] stl, input int stall_cycles);
        exp_t e;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_sel_i  = sel;
        cpu_data_i = wdat;
        stall_i    = '0;
        @(negedge clk);
        chk("req_stallreq", stallreq_o, 1'b1);
        chk("req_cyc", wb_cyc_o, 1'b0);
        step();
        for (int k = 0; k < ack_delay; k++) begin
            wb_dat_i = $urandom;
            @(negedge clk);
            chk("busy_cyc", wb_cyc_o, 1'b1);
            chk("busy_stb", wb_stb_o, 1'b1);
            chk("busy_adr", wb_adr_o, addr);
            chk("busy_we", wb_we_o, we);
            chk("busy_sel", wb_sel_o, sel);
            chk("busy_dat", wb_dat_o, wdat);
            chk("busy_stallreq", stallreq_o, 1'b1);
            chk("busy_data", cpu_data_o, 32'h0);
            step();
        end
        wb_ack_i = 1'b1;
        wb_dat_i = rdat;
        stall_i  = stl;
        e.we     = we;
        e.rdat   = rdat;
        sb.push_back(e);
        if (!we) last_rd = rdat;
        @(negedge clk);
        chk("ack_adr", wb_adr_o, addr);
        step();
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
        if (stl != '0) begin
            // MEM keeps its request up while stalled; it must not start a new cycle.
            for (int i = 0; i < stall_cycles; i++) begin
                @(negedge clk);
                chk("wait_data", cpu_data_o, last_rd);
                chk("wait_stallreq", stallreq_o, 1'b0);
                chk("wait_cyc", wb_cyc_o, 1'b0);
                step();
            end
            stall_i  = '0;
            cpu_ce_i = 1'b0;
            @(negedge clk);
            chk("wait_last_data", cpu_data_o, last_rd);
            step();
        end else begin
            cpu_ce_i = 1'b0;
        end
        @(negedge clk);
        chk("post_cyc", wb_cyc_o, 1'b0);
        chk("post_stb", wb_stb_o, 1'b0);
        // Idle probe: only IDLE answers a request with a stall request.
        cpu_ce_i = 1'b1;
        #1;
        chk("idle_stallreq", stallreq_o, 1'b1);
        chk("idle_data", cpu_data_o, 32'h0);
        cpu_ce_i = 1'b0;
        step();
    endtask

    initial begin
        rst        = 1'b0;
        stall_i    = '0;
        flush_i    = 1'b0;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_sel_i  = 4'hF;
        cpu_addr_i = 32'h10;
        cpu_data_i = 32'h0;
        wb_dat_i   = 32'h0;
        wb_ack_i   = 1'b0;
        #2;
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_we", wb_we_o, 1'b0);
        chk("rst_sel", wb_sel_o, 4'h0);
        chk("rst_stallreq", stallreq_o, 1'b0);
        chk("rst_data", cpu_data_o, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst      = 1'b1;
        cpu_ce_i = 1'b0;
        step();

        do_access(1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 3, 6'b0, 0);
        do_access(1'b1, 32'h40, 4'b0011, 32'h1234, 32'h0, 2, 6'b0, 0);
        do_access(1'b0, 32'h80, 4'hF, 32'h0, 32'hCAFEF00D, 1, 6'b000011, 4);
        do_access(1'b0, 32'h84, 4'hF, 32'h0, 32'h0BADF00D, 0, 6'b0, 0);

        // Flush in BUSY, coinciding with an ack, then a late ack.
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h300;
        cpu_sel_i  = 4'hF;
        step();
        @(negedge clk);
        chk("fl_busy_cyc", wb_cyc_o, 1'b1);
        step();
        flush_i  = 1'b1;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hBAD0BAD0;
        @(negedge clk);
        chk("fl_stallreq", stallreq_o, 1'b0);
        chk("fl_data", cpu_data_o, 32'h0);
        step();
        flush_i  = 1'b0;
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("fl_late_cyc", wb_cyc_o, 1'b0);
            chk("fl_late_stb", wb_stb_o, 1'b0);
            chk("fl_late_data", cpu_data_o, 32'h0);
            chk("fl_late_stallreq", stallreq_o, 1'b0);
            step();
        end
        wb_ack_i = 1'b0;

        // Store held by a stall exposes the untouched read buffer.
        do_access(1'b1, 32'h44, 4'b1100, 32'h5555AAAA, 32'h0, 1, 6'b000001, 2);

        // Asynchronous reset while cyc is high.
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h200;
        cpu_data_i = 32'h77;
        step();
        chk("ar_cyc_before", wb_cyc_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cyc", wb_cyc_o, 1'b0);
        chk("ar_stb", wb_stb_o, 1'b0);
        chk("ar_adr", wb_adr_o, 32'h0);
        chk("ar_dat", wb_dat_o, 32'h0);
        chk("ar_stallreq", stallreq_o, 1'b0);
        chk("ar_data", cpu_data_o, 32'h0);
        step();
        chk("ar_hold_cyc", wb_cyc_o, 1'b0);
        #2;
        rst      = 1'b1;
        cpu_ce_i = 1'b0;
        last_rd  = '0;
        step();
        do_access(1'b0, 32'h204, 4'hF, 32'h0, 32'h13579BDF, 0, 6'b0, 0);
        do_access(1'b1, 32'h48, 4'b0001, 32'hA5, 32'h0, 0, 6'b100000, 1);

        for (int i = 0; i < 6; i++) begin
            logic        we;
            logic [5:0]  stl;
            we  = 1'($urandom_range(0, 1));
            stl = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'b0;
            do_access(we, {$urandom} & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)), $urandom,
                      $urandom, $urandom_range(0, 3), stl, $urandom_range(0, 2));
        end

        chk("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
